btn_debounce: RTL and testbench

//  - Front-end conditioner for the 4 raw EGO1 push-buttons. Feeds the btn[3:0] input of the press decoder.
//  - Synchronises each asynchronous pad into clk with a 2-flop synchroniser.
//  - Filters contact bounce with a per-channel stability counter.
//  - Outputs: a clean level per button, plus a single-cycle rising-edge pulse per button.

---
 rtl/btn_debounce_pkg.sv | 10 +
 rtl/btn_debounce_if.sv | 16 +
 rtl/btn_debounce_chan.sv | 59 +++++
 rtl/btn_debounce.sv | 26 ++
 tb/tb_btn_debounce.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared constants for the push-button front end: channel count, debounce windows
// for hardware and simulation builds, and the default counter width.
package btn_debounce_pkg;

  localparam int unsigned N_BTN         = 4;
  localparam int unsigned DB_CYCLES_HW  = 2_000_000;
  localparam int unsigned DB_CYCLES_SIM = 8;
  localparam int unsigned CNT_W         = 21;

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle between the pads and the debouncer: raw pad levels in, clean level
// and press pulse out.
interface btn_debounce_if
  import btn_debounce_pkg::*;
#(
  parameter int unsigned N = N_BTN
);

  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_clean;
  logic [N-1:0] btn_rise;

  modport master (output btn_raw, input btn_clean, input btn_rise);
  modport slave  (input btn_raw, output btn_clean, output btn_rise);

endinterface

// File: rtl/btn_debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, registered clean
// level and a single-cycle press pulse.
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DbCycles = DB_CYCLES_HW,
  parameter int unsigned CntW     = CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise
);

  localparam logic [CntW-1:0] CntLast = CntW'(DbCycles - 1);

  logic            s1_q, s2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clean_q, clean_d;
  logic            rise_q, rise_d;

  // Any sample that agrees with the clean level restarts the window, so only an
  // uninterrupted run of DbCycles disagreeing samples flips the output.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    if (s2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      clean_d = s2_q;
      cnt_d   = '0;
      rise_d  = s2_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: N_BTN independent debounce channels. Simultaneous presses
// may give a multi-hot btn_rise; the consumer rejects those.
module btn_debounce #(
  parameter int unsigned N_BTN     = btn_debounce_pkg::N_BTN,
  parameter int unsigned DB_CYCLES = btn_debounce_pkg::DB_CYCLES_HW,
  parameter int unsigned CNT_W     = btn_debounce_pkg::CNT_W
) (
  input logic             clk,
  input logic             rst,
  btn_debounce_if.slave   bus
);

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_chan
    btn_debounce_chan #(
      .DbCycles (DB_CYCLES),
      .CntW     (CNT_W)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.btn_raw[i]),
      .clean (bus.btn_clean[i]),
      .rise  (bus.btn_rise[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with an 8-cycle window; expected values are
// hand-computed edge counts from each input change.
module tb_btn_debounce;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  btn_debounce_if #(.N(4)) bus ();

  btn_debounce #(
    .N_BTN     (4),
    .DB_CYCLES (8),
    .CNT_W     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.btn_raw = 4'hF;

    // 1: outputs held low throughout reset even with every pad pressed
    #1;
    chk("rst_clean_t0", bus.btn_clean, 4'h0);
    chk("rst_rise_t0", bus.btn_rise, 4'h0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("rst_clean", bus.btn_clean, 4'h0);
      chk("rst_rise", bus.btn_rise, 4'h0);
    end
    bus.btn_raw = 4'h0;
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("idle_clean", bus.btn_clean, 4'h0);

    // 2: clean press of btn 2; accepted on the 10th edge after the change
    bus.btn_raw = 4'h4;
    tick(9);
    chk("p2_clean_e9", bus.btn_clean, 4'h0);
    chk("p2_rise_e9", bus.btn_rise, 4'h0);
    tick(1);
    chk("p2_clean_e10", bus.btn_clean, 4'h4);
    chk("p2_rise_e10", bus.btn_rise, 4'h4);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("p2_hold_rise", bus.btn_rise, 4'h0);
      chk("p2_hold_clean", bus.btn_clean, 4'h4);
    end

    // 3: btn 0 toggles every 3 cycles (13 toggles, ends high), then holds
    for (int t = 0; t < 13; t++) begin
      bus.btn_raw[0] = ~bus.btn_raw[0];
      for (int k = 0; k < 3; k++) begin
        tick(1);
        chk("bnc_clean", bus.btn_clean, 4'h4);
        chk("bnc_rise", bus.btn_rise, 4'h0);
      end
    end
    tick(6);
    chk("bnc_clean_e9", bus.btn_clean, 4'h4);
    tick(1);
    chk("bnc_clean_e10", bus.btn_clean, 4'h5);
    chk("bnc_rise_e10", bus.btn_rise, 4'h1);
    tick(1);
    chk("bnc_rise_e11", bus.btn_rise, 4'h0);

    // 4: release of both held buttons; no pulse on release
    bus.btn_raw = 4'h0;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      chk("rel_clean", bus.btn_clean, 4'h5);
      chk("rel_rise", bus.btn_rise, 4'h0);
    end
    tick(1);
    chk("rel_clean_e10", bus.btn_clean, 4'h0);
    chk("rel_rise_e10", bus.btn_rise, 4'h0);
    tick(1);
    chk("rel_rise_e11", bus.btn_rise, 4'h0);

    // 5: btn 1 and btn 3 rise together; buttons stay held into step 6
    bus.btn_raw = 4'hA;
    tick(9);
    chk("dual_clean_e9", bus.btn_clean, 4'h0);
    tick(1);
    chk("dual_clean_e10", bus.btn_clean, 4'hA);
    chk("dual_rise_e10", bus.btn_rise, 4'hA);
    tick(1);
    chk("dual_rise_e11", bus.btn_rise, 4'h0);
    chk("dual_clean_e11", bus.btn_clean, 4'hA);

    // 6: press btn 2, reset mid-cycle at count 5, everything re-accepted after release
    bus.btn_raw = 4'hE;
    tick(7);
    chk("pre_rst_clean", bus.btn_clean, 4'hA);
    rst = 1'b1;
    #2;
    chk("async_clean", bus.btn_clean, 4'h0);
    chk("async_rise", bus.btn_rise, 4'h0);
    tick(2);
    chk("in_rst_clean", bus.btn_clean, 4'h0);
    rst = 1'b0;
    tick(9);
    chk("post_rst_clean_e9", bus.btn_clean, 4'h0);
    chk("post_rst_rise_e9", bus.btn_rise, 4'h0);
    tick(1);
    chk("post_rst_clean_e10", bus.btn_clean, 4'hE);
    chk("post_rst_rise_e10", bus.btn_rise, 4'hE);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("post_rst_rise_hold", bus.btn_rise, 4'h0);
      chk("post_rst_clean_hold", bus.btn_clean, 4'hE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
